// File: rtl/pwm_3ph_deadtime.sv
// Three-phase complementary PWM generator. A shared edge- or center-aligned counter
// feeds per-channel comparators, and dead time is inserted on every raw-state change.
module pwm_3ph_deadtime #(
  parameter int CW  = 10,
  parameter int DTW = 6,
  parameter int NCH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CW-1:0]     period,
  input  logic [NCH*CW-1:0] duty,
  input  logic [DTW-1:0]    deadtime,
  input  logic              center_mode,
  input  logic              load,
  output logic [NCH-1:0]    pwm_hi,
  output logic [NCH-1:0]    pwm_lo,
  output logic              period_start,
  output logic              load_ack
);

  logic [CW-1:0]     pend_period, act_period;
  logic [NCH*CW-1:0] pend_duty, act_duty;
  logic [DTW-1:0]    pend_dt, act_dt;
  logic              pend_center, act_center;
  logic              pend_valid;

  logic [CW-1:0]     counter, counter_nxt;
  logic              dir_down, dir_nxt;
  logic [NCH-1:0]    raw, raw_nxt;
  logic [NCH-1:0]    seen;
  logic [DTW-1:0]    dt_cnt [NCH];

  logic              boundary, apply;
  logic [CW-1:0]     eff_period;
  logic [NCH*CW-1:0] eff_duty;
  logic              eff_center;

  // On the boundary edge that applies the pending set, the new values already
  // steer the counter step and the compare, so the new period starts cleanly.
  always_comb begin
    boundary    = enable && (counter == '0);
    apply       = boundary && pend_valid;
    eff_period  = apply ? pend_period : act_period;
    eff_duty    = apply ? pend_duty   : act_duty;
    eff_center  = apply ? pend_center : act_center;
    counter_nxt = counter;
    dir_nxt     = 1'b0;
    raw_nxt     = '0;
    if (!eff_center) begin
      counter_nxt = (counter >= eff_period) ? '0 : counter + 1'b1;
    end else if (dir_down && (counter != '0)) begin
      counter_nxt = counter - 1'b1;
      dir_nxt     = (counter != CW'(1));
    end else if (counter >= eff_period) begin
      counter_nxt = (eff_period == '0) ? '0 : counter - 1'b1;
      dir_nxt     = (eff_period != '0);
    end else begin
      counter_nxt = counter + 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      raw_nxt[i] = (eff_period != '0) && (counter < eff_duty[i*CW +: CW]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_period  <= '0;
      pend_duty    <= '0;
      pend_dt      <= '0;
      pend_center  <= 1'b0;
      pend_valid   <= 1'b0;
      act_period   <= '0;
      act_duty     <= '0;
      act_dt       <= '0;
      act_center   <= 1'b0;
      counter      <= '0;
      dir_down     <= 1'b0;
      raw          <= '0;
      period_start <= 1'b0;
      load_ack     <= 1'b0;
    end else begin
      if (load) begin
        pend_period <= period;
        pend_duty   <= duty;
        pend_dt     <= deadtime;
        pend_center <= center_mode;
      end
      if (apply) begin
        act_period <= pend_period;
        act_duty   <= pend_duty;
        act_dt     <= pend_dt;
        act_center <= pend_center;
      end
      pend_valid   <= load | (pend_valid & ~apply);
      load_ack     <= apply;
      period_start <= boundary;
      if (enable) begin
        counter  <= counter_nxt;
        dir_down <= dir_nxt;
        raw      <= raw_nxt;
      end else begin
        counter  <= '0;
        dir_down <= 1'b0;
        raw      <= '0;
      end
    end
  end

  // Any raw change (even inside a running window) restarts the dead-time count;
  // only once it expires is the side matching the latest raw state driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen   <= '0;
      pwm_hi <= '0;
      pwm_lo <= '0;
      for (int i = 0; i < NCH; i++) dt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!enable) begin
          seen[i]   <= 1'b0;
          dt_cnt[i] <= '0;
          pwm_hi[i] <= 1'b0;
          pwm_lo[i] <= 1'b0;
        end else if (raw[i] != seen[i]) begin
          seen[i] <= raw[i];
          if (act_dt == '0) begin
            dt_cnt[i] <= '0;
            pwm_hi[i] <= raw[i];
            pwm_lo[i] <= ~raw[i];
          end else begin
            dt_cnt[i] <= act_dt;
            pwm_hi[i] <= 1'b0;
            pwm_lo[i] <= 1'b0;
          end
        end else if (dt_cnt[i] > DTW'(1)) begin
          dt_cnt[i] <= dt_cnt[i] - 1'b1;
          pwm_hi[i] <= 1'b0;
          pwm_lo[i] <= 1'b0;
        end else begin
          dt_cnt[i] <= '0;
          pwm_hi[i] <= seen[i];
          pwm_lo[i] <= ~seen[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_3ph_deadtime.sv
// Directed bench for pwm_3ph_deadtime: edge/center timing, shadow loading,
// dead-time insertion, duty extremes and reset/enable recovery.
module tb_pwm_3ph_deadtime;
  localparam int CW  = 10;
  localparam int DTW = 6;
  localparam int NCH = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [CW-1:0]     period;
  logic [NCH*CW-1:0] duty;
  logic [DTW-1:0]    deadtime;
  logic              center_mode;
  logic              load;
  logic [NCH-1:0]    pwm_hi;
  logic [NCH-1:0]    pwm_lo;
  logic              period_start;
  logic              load_ack;

  int vec_count   = 0;
  int miscompares = 0;

  pwm_3ph_deadtime #(.CW(CW), .DTW(DTW), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period), .duty(duty),
    .deadtime(deadtime), .center_mode(center_mode), .load(load),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_start(period_start), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Disable, present a shadow set and pulse load for one cycle; enable stays low.
  task automatic reload(input int per, input int d0, input int d1, input int d2,
                        input int dt, input logic ctr);
    enable      = 1'b0;
    period      = CW'(per);
    duty        = {CW'(d2), CW'(d1), CW'(d0)};
    deadtime    = DTW'(dt);
    center_mode = ctr;
    load        = 1'b1;
    tick();
    load        = 1'b0;
  endtask

  // Edge-mode raw state after edge m for a given period and duty (m=0 is disabled).
  function automatic logic edge_raw(input int m, input int per, input int d);
    return (m >= 1) && (((m - 1) % (per + 1)) < d);
  endfunction

  task automatic test_reset();
    tick();
    tick();
    vec_count++;
    if (pwm_hi !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_hi: got %b expected 000", pwm_hi); end
    vec_count++;
    if (pwm_lo !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_lo: got %b expected 000", pwm_lo); end
    vec_count++;
    if (period_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ps: got %b expected 0", period_start); end
    vec_count++;
    if (load_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack: got %b expected 0", load_ack); end
    reset = 1'b0;
  endtask

  task automatic test_edge_mode();
    logic eh;
    reload(9, 4, 0, 0, 0, 1'b0);
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      eh = edge_raw(k - 1, 9, 4);
      vec_count++;
      if (pwm_hi !== {2'b00, eh}) begin miscompares++; $display("[TB] FAIL edge_hi k=%0d: got %b expected %b", k, pwm_hi, {2'b00, eh}); end
      vec_count++;
      if (pwm_lo !== {2'b11, ~eh}) begin miscompares++; $display("[TB] FAIL edge_lo k=%0d: got %b expected %b", k, pwm_lo, {2'b11, ~eh}); end
      vec_count++;
      if (period_start !== ((k - 1) % 10 == 0)) begin miscompares++; $display("[TB] FAIL edge_ps k=%0d: got %b", k, period_start); end
      vec_count++;
      if (load_ack !== (k == 1)) begin miscompares++; $display("[TB] FAIL edge_ack k=%0d: got %b", k, load_ack); end
    end
  endtask

  task automatic test_load_midperiod();
    logic eh;
    int d;
    for (int k = 31; k <= 60; k++) begin
      tick();
      if (k == 34) load = 1'b0;
      d  = (k - 1 >= 41) ? 7 : 4;
      eh = edge_raw(k - 1, 9, d);
      vec_count++;
      if (pwm_hi !== {2'b00, eh}) begin miscompares++; $display("[TB] FAIL mid_hi k=%0d: got %b expected %b", k, pwm_hi, {2'b00, eh}); end
      vec_count++;
      if (pwm_lo !== {2'b11, ~eh}) begin miscompares++; $display("[TB] FAIL mid_lo k=%0d: got %b expected %b", k, pwm_lo, {2'b11, ~eh}); end
      vec_count++;
      if (load_ack !== (k == 41)) begin miscompares++; $display("[TB] FAIL mid_ack k=%0d: got %b expected %b", k, load_ack, (k == 41)); end
      vec_count++;
      if (period_start !== ((k - 1) % 10 == 0)) begin miscompares++; $display("[TB] FAIL mid_ps k=%0d: got %b", k, period_start); end
      if (k == 33) begin
        duty[CW-1:0] = CW'(7);
        load = 1'b1;
      end
    end
  endtask

  task automatic test_center_deadtime();
    int st;
    int q;
    reload(8, 4, 0, 0, 2, 1'b1);
    vec_count++;
    if ((pwm_hi !== 3'b000) || (pwm_lo !== 3'b000)) begin miscompares++; $display("[TB] FAIL disabled_out: got hi=%b lo=%b expected 000/000", pwm_hi, pwm_lo); end
    vec_count++;
    if (period_start !== 1'b0) begin miscompares++; $display("[TB] FAIL disabled_ps: got %b expected 0", period_start); end
    enable = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      // st: 0 both low, 1 high side, 2 low side
      if (j >= 15) begin
        q  = (j - 15) % 16;
        st = (q < 2) ? 0 : (q < 7) ? 1 : (q < 9) ? 0 : 2;
      end else if (j == 1 || j >= 8) st = 2;
      else if (j == 4 || j == 5) st = 1;
      else st = 0;
      vec_count++;
      if (pwm_hi !== {2'b00, st == 1}) begin miscompares++; $display("[TB] FAIL ctr_hi j=%0d: got %b expected %b", j, pwm_hi, {2'b00, st == 1}); end
      vec_count++;
      if (pwm_lo !== {2'b11, st == 2}) begin miscompares++; $display("[TB] FAIL ctr_lo j=%0d: got %b expected %b", j, pwm_lo, {2'b11, st == 2}); end
      vec_count++;
      if ((pwm_hi & pwm_lo) !== 3'b000) begin miscompares++; $display("[TB] FAIL ctr_overlap j=%0d: got %b expected 000", j, pwm_hi & pwm_lo); end
      vec_count++;
      if (period_start !== ((j - 1) % 16 == 0)) begin miscompares++; $display("[TB] FAIL ctr_ps j=%0d: got %b", j, period_start); end
    end
  endtask

  task automatic test_duty_extremes();
    reload(5, 0, 6, 3, 2, 1'b0);
    enable = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      tick();
      vec_count++;
      if ((pwm_hi & pwm_lo) !== 3'b000) begin miscompares++; $display("[TB] FAIL ext_overlap j=%0d: got %b expected 000", j, pwm_hi & pwm_lo); end
      if (j >= 7) begin
        vec_count++;
        if (pwm_hi[1:0] !== 2'b10) begin miscompares++; $display("[TB] FAIL ext_hi j=%0d: got %b expected 10", j, pwm_hi[1:0]); end
        vec_count++;
        if (pwm_lo[1:0] !== 2'b01) begin miscompares++; $display("[TB] FAIL ext_lo j=%0d: got %b expected 01", j, pwm_lo[1:0]); end
      end
    end
  endtask

  task automatic test_reset_restart();
    logic eh;
    vec_count++;
    if (pwm_hi[1] !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_hi: got %b expected 1", pwm_hi[1]); end
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    vec_count++;
    if ((pwm_hi !== 3'b000) || (pwm_lo !== 3'b000)) begin miscompares++; $display("[TB] FAIL async_reset: got hi=%b lo=%b expected 000/000", pwm_hi, pwm_lo); end
    tick();
    tick();
    vec_count++;
    if ((pwm_hi !== 3'b000) || (pwm_lo !== 3'b000) || (period_start !== 1'b0) || (load_ack !== 1'b0)) begin
      miscompares++; $display("[TB] FAIL in_reset: got hi=%b lo=%b ps=%b ack=%b expected all 0", pwm_hi, pwm_lo, period_start, load_ack);
    end
    reset = 1'b0;
    reload(9, 4, 0, 0, 0, 1'b0);
    tick();
    vec_count++;
    if ((pwm_hi !== 3'b000) || (pwm_lo !== 3'b000) || (period_start !== 1'b0)) begin
      miscompares++; $display("[TB] FAIL en_low: got hi=%b lo=%b ps=%b expected all 0", pwm_hi, pwm_lo, period_start);
    end
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      eh = edge_raw(k - 1, 9, 4);
      vec_count++;
      if (pwm_hi !== {2'b00, eh}) begin miscompares++; $display("[TB] FAIL restart_hi k=%0d: got %b expected %b", k, pwm_hi, {2'b00, eh}); end
      vec_count++;
      if (period_start !== ((k - 1) % 10 == 0)) begin miscompares++; $display("[TB] FAIL restart_ps k=%0d: got %b", k, period_start); end
      vec_count++;
      if (load_ack !== (k == 1)) begin miscompares++; $display("[TB] FAIL restart_ack k=%0d: got %b", k, load_ack); end
    end
  endtask

  task automatic test_short_pulse();
    logic el;
    reload(9, 1, 0, 0, 3, 1'b0);
    enable = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      tick();
      el = (j == 1) || !((j % 10 >= 2) && (j % 10 <= 5));
      vec_count++;
      if (pwm_hi !== 3'b000) begin miscompares++; $display("[TB] FAIL short_hi j=%0d: got %b expected 000", j, pwm_hi); end
      vec_count++;
      if (pwm_lo[0] !== el) begin miscompares++; $display("[TB] FAIL short_lo j=%0d: got %b expected %b", j, pwm_lo[0], el); end
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    period      = '0;
    duty        = '0;
    deadtime    = '0;
    center_mode = 1'b0;
    load        = 1'b0;
    $display("[TB] starting pwm_3ph_deadtime bench");
    test_reset();
    test_edge_mode();
    test_load_midperiod();
    test_center_deadtime();
    test_duty_extremes();
    test_reset_restart();
    test_short_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
